// File: rtl/ghash_stage_pipe_skid.sv
// rtl/ghash_stage_pipe_skid.sv - N-lane GHASH input stage with 2-entry skid buffer
// Registers data, lane-mapped H powers, feedback operand and sideband behind a valid/ready handshake.
module ghash_stage_pipe_skid #(
   parameter int NB_BLOCK  = 128,
   parameter int N_BLOCKS  = 2,
   parameter int NB_DATA   = N_BLOCKS * NB_BLOCK,
   parameter bit H_REVERSE = 1'b1
) (
   input  logic                i_clock,
   input  logic                i_reset_n,
   input  logic                i_clear,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [NB_DATA-1:0]  i_data_x,
   input  logic [NB_DATA-1:0]  i_h_pow,
   input  logic [NB_BLOCK-1:0] i_feedback_mux,
   input  logic                i_stall,
   input  logic                i_last,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [NB_DATA-1:0]  o_data_x,
   output logic [NB_DATA-1:0]  o_h_pow,
   output logic [NB_BLOCK-1:0] o_feedback_mux,
   output logic                o_stall,
   output logic                o_last,
   output logic [1:0]          o_level
);

   localparam int BW = 2 * NB_DATA + NB_BLOCK + 2;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              ready_q;
   logic              accept;
   logic              pop;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid;
   logic [NB_DATA-1:0] h_mapped;
   logic [BW-1:0]     beat_in;
   logic [BW-1:0]     main_q;
   logic [BW-1:0]     skid_q;

   // Lane mapping is fixed at elaboration and applied before capture.
   for (genvar k = 0; k < N_BLOCKS; k++) begin : g_lane
      if (H_REVERSE) begin : g_rev
         assign h_mapped[k*NB_BLOCK +: NB_BLOCK] = i_h_pow[(N_BLOCKS-1-k)*NB_BLOCK +: NB_BLOCK];
      end else begin : g_str
         assign h_mapped[k*NB_BLOCK +: NB_BLOCK] = i_h_pow[k*NB_BLOCK +: NB_BLOCK];
      end
   end

   assign beat_in = {i_data_x, h_mapped, i_feedback_mux, i_stall, i_last};
   assign accept  = i_valid & ready_q;
   assign pop     = (state_q != S_EMPTY) & i_ready;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != S_FULL);
      end
   end

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (i_clear) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  state_d      = S_ONE;
                  load_main_in = 1'b1;
               end
            end
            S_ONE: begin
               if (accept && pop) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  state_d   = S_FULL;
                  load_skid = 1'b1;
               end else if (pop) begin
                  state_d = S_EMPTY;
               end
            end
            S_FULL: begin
               if (pop) begin
                  state_d        = S_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   always_comb begin
      o_valid = (state_q != S_EMPTY);
      o_level = state_q;
      o_ready = ready_q;
   end

   // Payload never changes unless the FSM explicitly loads it, so a stalled beat stays stable.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= beat_in;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= beat_in;
         end
      end
   end

   assign {o_data_x, o_h_pow, o_feedback_mux, o_stall, o_last} = main_q;

endmodule

// File: doc/ghash_stage_pipe_skid.md
Name: ghash_stage_pipe_skid

Overview:
Parametrised, back-pressurable input pipeline stage for the multi-lane GHASH datapath. It registers N_BLOCKS data blocks, N_BLOCKS H-power blocks, the feedback-mux operand and the stall/last sideband, with a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered o_ready. It sits between the H-power table / data aligner and the stage-2 GF(2^128) multiplier array. It generalises the fixed 2-lane even/odd stage to N lanes with optional H-power lane reversal and flush.

Parameters:
NB_BLOCK, 128, bits per GF(2^128) block
N_BLOCKS, 2, parallel lanes (>=1)
NB_DATA, N_BLOCKS*NB_BLOCK, width of the data and H-power buses
H_REVERSE, 1, 1: output H lane j = input H lane N_BLOCKS-1-j; 0: straight mapping

Ports:
i_clock  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_clear  in  1  synchronous flush, discards all held beats
i_valid  in  1  upstream beat valid
o_ready  out  1  stage can accept a beat
i_data_x  in  NB_DATA  data blocks, lane k at [k*NB_BLOCK+:NB_BLOCK]
i_h_pow  in  NB_DATA  H powers, same lane layout
i_feedback_mux  in  NB_BLOCK  accumulator feedback operand
i_stall  in  1  stall sideband
i_last  in  1  last beat of message
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts
o_data_x  out  NB_DATA  registered data blocks
o_h_pow  out  NB_DATA  registered, lane-mapped H powers
o_feedback_mux  out  NB_BLOCK  registered feedback operand
o_stall  out  1  registered stall sideband
o_last  out  1  registered last flag
o_level  out  2  beats held (0..2)

Behaviour:
- Reset (i_reset_n=0, async assert, sync-deasserted upstream): o_valid=0, o_ready=1, o_level=0; all payload outputs and both storage entries = 0; skid flag = 0.
- Storage: main register (drives outputs) + skid register. Beat = {data_x, h_pow mapped, feedback_mux, stall, last}; lane mapping is applied on capture.
- Accept = i_valid & o_ready; Pop = o_valid & i_ready.
- o_ready registered: o_ready = ~skid_full. Never combinationally dependent on i_ready.
- Latency: beat accepted at edge N appears on outputs after edge N (1 cycle) when the main register is empty or popping.
- States (o_level): EMPTY(0), ONE(1), FULL(2).
  EMPTY: Accept -> ONE (load main).
  ONE: Accept & Pop -> ONE (main <= input). Accept & ~Pop -> FULL (skid <= input, o_ready->0). ~Accept & Pop -> EMPTY. Otherwise hold.
  FULL: Pop -> ONE (main <= skid, o_ready->1). i_valid ignored (o_ready=0).
- Order strictly FIFO. A held beat never changes while o_valid & ~i_ready.
- i_clear: next edge -> EMPTY, o_valid=0, o_ready=1; a same-cycle Accept is discarded; payload registers keep their values (don't care).
- Async reset mid-operation: immediate EMPTY; no partial beat is emitted after release.
- Payload outputs hold their last value when o_valid=0.
- o_level is 0 in EMPTY, 1 in ONE, 2 in FULL.
- Widths: pure wiring, no arithmetic. NB_DATA must equal N_BLOCKS*NB_BLOCK.

Test Plan:
- Reset: hold i_reset_n=0 with i_valid=1 -> o_valid=0, o_ready=1, o_level=0, all outputs 0; release -> first beat appears 1 cycle after accept.
- Lane map, N_BLOCKS=4, H_REVERSE=1, i_h_pow lanes {3,2,1,0}={0xD,0xC,0xB,0xA} -> o_h_pow lanes {3..0}={0xA,0xB,0xC,0xD}; o_data_x unchanged. H_REVERSE=0 -> identical to input.
- Streaming with i_ready=1: 8 back-to-back beats, data=1..8 -> outputs 1..8 on consecutive cycles, o_level=1 throughout, o_ready never drops.
- Backpressure: i_ready=0, push beats 1,2 -> o_level=2, o_ready=0 the cycle after beat 2; beat 3 held by upstream; i_ready=1 -> outputs 1,2,3 in order, no loss or duplication.
- Flush: FULL with i_clear=1 and i_valid=1 same cycle -> next cycle o_valid=0, o_level=0, o_ready=1, the cleared beat is never output; o_stall and o_last follow their beats (last=1 on beat 3 -> o_last=1 only on beat 3).
- Random valid/ready (10k beats), async reset pulse mid-stream -> scoreboard order matches, and o_valid drops asynchronously on reset assertion.
